uart_rx_core: RTL and testbench
===============================

Name: uart_rx_core

Overview:
- Receive front end of the USRT: programmable baud-clock generator plus an 8-bit serial receive shifter, both clocked by one system clock.
- The generator divides i_Pclk into a square-wave bit clock o_Bclk with one bit period per o_Bclk period.
- The shifter samples i_Rx_Serial mid-bit, assembles an 8N1 frame LSB first, and presents the byte with a one-cycle done strobe.

Parameters:
- BAUD_WIDTH, 14, width of the i_Baud divisor input.
- DATA_BITS, 8, data bits per frame.

Ports:
- i_Pclk  input  1  system clock; all logic on its rising edge.
- i_Reset  input  1  synchronous, active-high reset.
- i_Baud  input  BAUD_WIDTH  half bit period, in i_Pclk cycles.
- i_Enable  input  1  receiver enable.
- i_Rx_Serial  input  1  serial line; idle high.
- o_Bclk  output  1  bit clock; period is 2*i_Baud i_Pclk cycles.
- o_Data  output  DATA_BITS  last correctly framed byte.
- o_Done  output  1  one-cycle strobe; o_Data has just been updated.

Behaviour:
- Reset (synchronous, active-high, dominates all other inputs): divider counter=0, o_Bclk=0, state IDLE, shift register=0, bit counter=0, o_Data=0, o_Done=0.

Baud generator:
- Counter increments every i_Pclk cycle.
- When counter >= i_Baud-1: counter returns to 0 and o_Bclk toggles. Using >= means a reduced i_Baud takes effect without wrap-around.
- i_Baud=0 is treated as 1, so o_Bclk toggles every cycle.
- After reset: first o_Bclk rise is i_Baud cycles after reset deassertion. High and low phases are i_Baud cycles each.
- The generator runs regardless of i_Enable.
- Example: i_Baud=87 at a 100 ns clock gives a 17.4 us bit period.

Receive shifter:
- Sample strobe: a registered copy of o_Bclk detects each falling edge. i_Rx_Serial is sampled on the i_Pclk cycle the fall is detected.
- A transmitter that changes data on o_Bclk rising edges is therefore sampled mid-bit.
- i_Rx_Serial is used directly, with no synchronizer; the line is assumed synchronous to i_Pclk.
- States:
  - IDLE: on a sample strobe with i_Enable=1 and line=0 (start bit), clear the bit counter and go to DATA.
  - DATA: on each strobe, shift the sample into the MSB (LSB-first reception) and increment the bit counter. After DATA_BITS samples, go to STOP.
  - STOP: on the next strobe:
    - Line=1: o_Data <= shift register, o_Done=1 for exactly one i_Pclk cycle, go to IDLE.
    - Line=0 (framing error): o_Data unchanged, no o_Done, go to IDLE.
- Latency: o_Done asserts on the i_Pclk edge after the stop-bit sampling cycle. o_Data is valid in the same cycle and holds until the next good frame.
- i_Enable=0 in any state forces IDLE on the next cycle, aborting a partial frame; o_Data is retained.
- A line held low after a framing error is seen as a new start bit on the next strobe.
- Back-to-back frames are supported: IDLE accepts a start bit on the strobe immediately after STOP.

Optional Feature:
- Macro RX_FRAMING_ERR_EN.
- Defined:
  - Adds output o_Frame_Err (1 bit, reset 0).
  - Pulses high for one i_Pclk cycle, same timing as o_Done, when the stop-bit sample is 0.
  - o_Done and o_Frame_Err are never high together.
- Undefined: the port does not exist; framing errors are silently dropped.

Test Plan:
- Reset/baud: i_Baud=87 after reset -> o_Bclk first rises 87 cycles after reset release. Period 174 cycles, 50% duty. o_Data=0, o_Done=0.
- Nominal frame: i_Enable=1, i_Baud=87; at an o_Bclk rise, drive start 0, then bits of 0x53 LSB first, then stop 1, each for 174 cycles -> single-cycle o_Done with o_Data=0x53.
- Back-to-back: frames 0xA5 then 0x3C with no idle gap -> two o_Done pulses, o_Data=0xA5 then 0x3C.
- Framing error: 0xFF sent with stop bit 0 -> no o_Done; o_Data keeps the previous value; o_Frame_Err pulses if RX_FRAMING_ERR_EN is defined.
- Enable/reset abort: drop i_Enable (or assert i_Reset) mid-DATA, re-enable, send 0x81 -> only 0x81 is reported; no spurious done. After i_Reset, o_Data=0.
- Divisor edge: i_Baud=1 and i_Baud=0 -> o_Bclk toggles every cycle. Frame 0x5A at a 2-cycle bit period -> o_Data=0x5A.

Source files
------------

// File: rtl/uart_rx_core.sv
// uart_rx_core: receive front end of the USRT.
// A programmable baud generator divides i_Pclk into the bit clock o_Bclk.
// An 8N1 receive shifter samples i_Rx_Serial on each falling edge of o_Bclk.
//
// Optional build macro RX_FRAMING_ERR_EN adds the o_Frame_Err pulse output.
// When the macro is undefined, framing errors are dropped silently.
//
// o_Rx_State is a debug tap of the receive FSM state:
//   0 = IDLE, 1 = DATA, 2 = STOP.
//
// Handshake: o_Done is a one-cycle strobe, with no backpressure.
//   o_Data is valid in the cycle o_Done is high.
//   o_Data then holds until the next correctly framed byte.
module uart_rx_core #(
  parameter int BAUD_WIDTH = 14,
  parameter int DATA_BITS  = 8
) (
  input  logic                  i_Pclk,
  input  logic                  i_Reset,
  input  logic [BAUD_WIDTH-1:0] i_Baud,
  input  logic                  i_Enable,
  input  logic                  i_Rx_Serial,
  output logic                  o_Bclk,
  output logic [DATA_BITS-1:0]  o_Data,
  output logic                  o_Done,
`ifdef RX_FRAMING_ERR_EN
  output logic                  o_Frame_Err,
`endif
  output logic [1:0]            o_Rx_State
);

  localparam int CNT_W = $clog2(DATA_BITS + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_STOP = 2'd2
  } state_t;

  // Baud generator signals.
  logic [BAUD_WIDTH-1:0] baud_cnt;
  logic [BAUD_WIDTH-1:0] baud_limit;
  logic                  bclk_q;
  logic                  sample_stb;

  // Receive shifter signals.
  state_t               state_q, state_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_d;
  logic                 done_d;
`ifdef RX_FRAMING_ERR_EN
  logic                 ferr_d;
`endif

  // A divisor of 0 behaves like 1, so o_Bclk toggles every cycle.
  // The >= compare lets a reduced divisor take effect without a counter wrap.
  assign baud_limit = (i_Baud == '0) ? '0 : i_Baud - BAUD_WIDTH'(1);

  // Divider counter; o_Bclk toggles each time the counter reaches the limit.
  always_ff @(posedge i_Pclk) begin
    if (i_Reset) begin
      baud_cnt <= '0;
      o_Bclk   <= 1'b0;
    end else if (baud_cnt >= baud_limit) begin
      baud_cnt <= '0;
      o_Bclk   <= ~o_Bclk;
    end else begin
      baud_cnt <= baud_cnt + BAUD_WIDTH'(1);
    end
  end

  // Delayed copy of o_Bclk, used to detect its falling edge.
  always_ff @(posedge i_Pclk) begin
    if (i_Reset) bclk_q <= 1'b0;
    else         bclk_q <= o_Bclk;
  end

  // A falling edge of o_Bclk is mid-bit for a transmitter that launches data on rising edges.
  assign sample_stb = bclk_q & ~o_Bclk;

  // Receive FSM register plus shifter, bit counter and output registers.
  always_ff @(posedge i_Pclk) begin
    if (i_Reset) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      o_Data    <= '0;
      o_Done    <= 1'b0;
`ifdef RX_FRAMING_ERR_EN
      o_Frame_Err <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      o_Data    <= data_d;
      o_Done    <= done_d;
`ifdef RX_FRAMING_ERR_EN
      o_Frame_Err <= ferr_d;
`endif
    end
  end

  // Next-state logic: disable aborts to IDLE, otherwise advance on each sample strobe.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    data_d    = o_Data;
    done_d    = 1'b0;
`ifdef RX_FRAMING_ERR_EN
    ferr_d    = 1'b0;
`endif
    if (!i_Enable) begin
      state_d = S_IDLE;
    end else if (sample_stb) begin
      case (state_q)
        S_IDLE: begin
          if (!i_Rx_Serial) begin
            bit_cnt_d = '0;
            state_d   = S_DATA;
          end
        end
        S_DATA: begin
          shift_d   = {i_Rx_Serial, shift_q[DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == CNT_W'(DATA_BITS - 1)) state_d = S_STOP;
        end
        S_STOP: begin
          state_d = S_IDLE;
          if (i_Rx_Serial) begin
            data_d = shift_q;
            done_d = 1'b1;
          end
`ifdef RX_FRAMING_ERR_EN
          else begin
            ferr_d = 1'b1;
          end
`endif
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign o_Rx_State = state_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: scoreboard bench for uart_rx_core.
// Expected bytes are queued as frames are driven.
// A negedge monitor pops the queue on every o_Done.
// Build with RX_FRAMING_ERR_EN defined to also cover the o_Frame_Err output.
module tb_uart_rx_core;

  localparam int BW = 14;
  localparam logic [1:0] ST_IDLE = 2'd0;

  logic          clk;
  logic          i_Reset;
  logic [BW-1:0] i_Baud;
  logic          i_Enable;
  logic          i_Rx_Serial;
  logic          o_Bclk;
  logic [7:0]    o_Data;
  logic          o_Done;
  logic [1:0]    rx_state;
`ifdef RX_FRAMING_ERR_EN
  logic          o_Frame_Err;
  int            ferr_expected;
  logic          ferr_prev;
`endif

  int         checks;
  int         failures;
  logic [7:0] exp_q[$];
  logic       done_prev;

  uart_rx_core #(.BAUD_WIDTH(BW), .DATA_BITS(8)) dut (
    .i_Pclk      (clk),
    .i_Reset     (i_Reset),
    .i_Baud      (i_Baud),
    .i_Enable    (i_Enable),
    .i_Rx_Serial (i_Rx_Serial),
    .o_Bclk      (o_Bclk),
    .o_Data      (o_Data),
    .o_Done      (o_Done),
`ifdef RX_FRAMING_ERR_EN
    .o_Frame_Err (o_Frame_Err),
`endif
    .o_Rx_State  (rx_state)
  );

  // Clock and reset block.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: pop the scoreboard on every o_Done pulse.
  always @(negedge clk) begin
    if (o_Done) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_done: got o_Done=1 with data %02h, expected no done", o_Data);
      end else begin
        logic [7:0] exp_b;
        exp_b = exp_q.pop_front();
        if (o_Data !== exp_b) begin
          failures++;
          $display("FAIL done_data: got %02h expected %02h", o_Data, exp_b);
        end
      end
      checks++;
      if (done_prev) begin
        failures++;
        $display("FAIL done_width: got o_Done high two cycles, expected one");
      end
    end
    done_prev <= o_Done;
  end

`ifdef RX_FRAMING_ERR_EN
  // Monitor: framing error pulses are counted against expected framing errors.
  always @(negedge clk) begin
    if (o_Frame_Err) begin
      checks++;
      if (ferr_expected == 0) begin
        failures++;
        $display("FAIL unexpected_ferr: got o_Frame_Err=1, expected 0");
      end else begin
        ferr_expected--;
      end
      checks++;
      if (o_Done || ferr_prev) begin
        failures++;
        $display("FAIL ferr_shape: got done=%0b prev=%0b, expected 0 0", o_Done, ferr_prev);
      end
    end
    ferr_prev <= o_Frame_Err;
  end
`endif

  // Driver tasks.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_bclk_rise(input int limit, output bit ok);
    logic prev;
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      prev = o_Bclk;
      tick(1);
      if (o_Bclk && !prev) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset(input logic [BW-1:0] baud);
    i_Reset = 1'b1;
    i_Baud  = baud;
    tick(3);
    i_Reset = 1'b0;
  endtask

  // Send start, 8 data bits LSB first and a stop bit, each lasting one o_Bclk period.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int beff);
    bit ok;
    wait_bclk_rise(4 * beff + 8, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL bclk_timeout: got no o_Bclk rise, expected one");
    end
    if (stop_bit) exp_q.push_back(b);
`ifdef RX_FRAMING_ERR_EN
    else ferr_expected++;
`endif
    i_Rx_Serial = 1'b0;
    tick(2 * beff);
    for (int i = 0; i < 8; i++) begin
      i_Rx_Serial = b[i];
      tick(2 * beff);
    end
    i_Rx_Serial = stop_bit;
    tick(2 * beff);
    i_Rx_Serial = 1'b1;
  endtask

  // Start a frame and stop driving it after nbits data bits.
  task automatic send_partial(input logic [7:0] b, input int nbits, input int beff);
    bit ok;
    wait_bclk_rise(4 * beff + 8, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL bclk_timeout: got no o_Bclk rise, expected one");
    end
    i_Rx_Serial = 1'b0;
    tick(2 * beff);
    for (int i = 0; i < nbits; i++) begin
      i_Rx_Serial = b[i];
      tick(2 * beff);
    end
    i_Rx_Serial = 1'b1;
  endtask

  task automatic check_drained(input string name, input int beff);
    tick(4 * beff + 4);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_drain: got %0d bytes pending, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Scenario tasks.
  task automatic test_reset;
    int n;
    do_reset(14'd87);
    checks++;
    if (o_Bclk !== 1'b0 || o_Data !== 8'h00 || o_Done !== 1'b0 || rx_state !== ST_IDLE) begin
      failures++;
      $display("FAIL reset_state: got bclk=%b data=%02h done=%b st=%0d, expected 0 00 0 0",
               o_Bclk, o_Data, o_Done, rx_state);
    end
    n = 0;
    while (o_Bclk !== 1'b1 && n < 400) begin tick(1); n++; end
    checks++;
    if (n != 87) begin
      failures++;
      $display("FAIL first_rise: got %0d cycles, expected 87", n);
    end
    n = 0;
    while (o_Bclk !== 1'b0 && n < 400) begin tick(1); n++; end
    checks++;
    if (n != 87) begin
      failures++;
      $display("FAIL high_phase: got %0d cycles, expected 87", n);
    end
    n = 0;
    while (o_Bclk !== 1'b1 && n < 400) begin tick(1); n++; end
    checks++;
    if (n != 87) begin
      failures++;
      $display("FAIL low_phase: got %0d cycles, expected 87", n);
    end
  endtask

  task automatic test_nominal;
    i_Enable = 1'b1;
    send_frame(8'h53, 1'b1, 87);
    check_drained("nominal", 87);
  endtask

  task automatic test_back_to_back;
    send_frame(8'hA5, 1'b1, 87);
    send_frame(8'h3C, 1'b1, 87);
    check_drained("b2b", 87);
  endtask

  task automatic test_framing_error;
    send_frame(8'hFF, 1'b0, 87);
    check_drained("ferr", 87);
    checks++;
    if (o_Data !== 8'h3C) begin
      failures++;
      $display("FAIL ferr_hold: got %02h expected 3c", o_Data);
    end
`ifdef RX_FRAMING_ERR_EN
    checks++;
    if (ferr_expected != 0) begin
      failures++;
      $display("FAIL ferr_missing: got %0d pulses outstanding, expected 0", ferr_expected);
      ferr_expected = 0;
    end
`endif
  endtask

  task automatic test_enable_abort;
    send_partial(8'hC7, 4, 87);
    i_Enable = 1'b0;
    tick(1);
    checks++;
    if (rx_state !== ST_IDLE) begin
      failures++;
      $display("FAIL abort_state: got %0d expected 0", rx_state);
    end
    tick(200);
    i_Enable = 1'b1;
    send_frame(8'h81, 1'b1, 87);
    check_drained("enable_abort", 87);
  endtask

  task automatic test_reset_abort;
    send_partial(8'h7E, 3, 87);
    i_Reset = 1'b1;
    tick(2);
    checks++;
    if (o_Data !== 8'h00 || o_Done !== 1'b0 || rx_state !== ST_IDLE) begin
      failures++;
      $display("FAIL reset_abort: got data=%02h done=%b st=%0d, expected 00 0 0",
               o_Data, o_Done, rx_state);
    end
    i_Reset = 1'b0;
    send_frame(8'h81, 1'b1, 87);
    check_drained("reset_abort", 87);
  endtask

  task automatic test_divisor_edge(input logic [BW-1:0] baud, input logic [7:0] b);
    logic prev;
    int   bad;
    do_reset(baud);
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      prev = o_Bclk;
      tick(1);
      if (o_Bclk === prev) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL div_toggle: baud=%0d got %0d non-toggling cycles, expected 0", baud, bad);
    end
    send_frame(b, 1'b1, 1);
    check_drained("divisor", 1);
    checks++;
    if (o_Data !== b) begin
      failures++;
      $display("FAIL div_data: got %02h expected %02h", o_Data, b);
    end
  endtask

  task automatic test_random;
    for (int k = 0; k < 4; k++) begin
      send_frame(8'($urandom_range(0, 255)), 1'b1, 1);
    end
    check_drained("random", 1);
  endtask

  // Main sequence and final report.
  initial begin
    checks      = 0;
    failures    = 0;
    done_prev   = 1'b0;
    i_Reset     = 1'b1;
    i_Baud      = 14'd87;
    i_Enable    = 1'b0;
    i_Rx_Serial = 1'b1;
`ifdef RX_FRAMING_ERR_EN
    ferr_expected = 0;
    ferr_prev     = 1'b0;
`endif
    test_reset();
    test_nominal();
    test_back_to_back();
    test_framing_error();
    test_enable_abort();
    test_reset_abort();
    test_divisor_edge(14'd1, 8'h5A);
    test_divisor_edge(14'd0, 8'hC3);
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
